// File: rtl/mlp_pkg.sv
// Shared definitions for the MLP datapath: default field widths, the MAC-pipeline
// bundle layout and the pipeline-stage state encodings.
package mlp_pkg;

   localparam int NEURON_W = 16;
   localparam int WEIGHT_W = 8;
   localparam int ADDR_W   = 12;

   typedef struct packed {
      logic                done;
      logic                reset_acc;
      logic                write_neuron;
      logic [ADDR_W-1:0]   addr;
      logic [WEIGHT_W-1:0] weight;
      logic [NEURON_W-1:0] neuron;
   } mlp_stage_bundle_t;

   // Encoded as {skid_valid, main_valid} so the state falls straight out of the slot flags.
   localparam logic [1:0] ST_EMPTY = 2'b00;
   localparam logic [1:0] ST_FULL  = 2'b01;
   localparam logic [1:0] ST_SKID  = 2'b11;

endpackage

// File: rtl/mlp_stage_slot.sv
// One pipeline storage slot: a valid flag plus a bundle register.
// Clear wins over load, and load wins over drop.
module mlp_stage_slot #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         drop,
   input  logic         clear,
   input  logic [W-1:0] data,
   output logic         valid,
   output logic [W-1:0] q
);

   // Drop only clears the flag; the data is kept and is qualified by valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         q     <= '0;
      end else if (clear) begin
         valid <= 1'b0;
         q     <= '0;
      end else if (load) begin
         valid <= 1'b1;
         q     <= data;
      end else if (drop) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/mlp_pipe_stage.sv
// Valid/ready pipeline stage for one MAC-pipeline bundle, with an optional
// two-entry skid buffer (registered in_ready) and a run-driven synchronous flush.
module mlp_pipe_stage
   import mlp_pkg::*;
#(
   parameter int NEURON_W = mlp_pkg::NEURON_W,
   parameter int WEIGHT_W = mlp_pkg::WEIGHT_W,
   parameter int ADDR_W   = mlp_pkg::ADDR_W,
   parameter int SKID     = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                run,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [NEURON_W-1:0] in_neuron,
   input  logic [WEIGHT_W-1:0] in_weight,
   input  logic [ADDR_W-1:0]   in_addr,
   input  logic                in_done,
   input  logic                in_reset_acc,
   input  logic                in_write_neuron,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [NEURON_W-1:0] out_neuron,
   output logic [WEIGHT_W-1:0] out_weight,
   output logic [ADDR_W-1:0]   out_addr,
   output logic                out_done,
   output logic                out_reset_acc,
   output logic                out_write_neuron
);

   typedef struct packed {
      logic                done;
      logic                reset_acc;
      logic                write_neuron;
      logic [ADDR_W-1:0]   addr;
      logic [WEIGHT_W-1:0] weight;
      logic [NEURON_W-1:0] neuron;
   } bundle_t;

   localparam int BW = $bits(bundle_t);

   bundle_t    in_bundle, main_q, main_d, skid_q;
   logic       main_valid, skid_valid;
   logic       accept, pop, flush;
   logic       main_load, main_drop, skid_load, skid_drop;
   logic [1:0] state;

   assign in_bundle = {in_done, in_reset_acc, in_write_neuron, in_addr, in_weight, in_neuron};
   assign accept    = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign flush     = !run;
   assign state     = {skid_valid, main_valid};
   assign main_d    = skid_valid ? skid_q : in_bundle;

   always_comb begin
      main_load = 1'b0;
      main_drop = 1'b0;
      skid_load = 1'b0;
      skid_drop = 1'b0;
      case (state)
         ST_EMPTY: main_load = accept;
         ST_FULL: begin
            if (accept && pop) begin
               main_load = 1'b1;
            end else if (accept) begin
               skid_load = 1'b1;
            end else if (pop) begin
               main_drop = 1'b1;
            end
         end
         ST_SKID: begin
            if (pop) begin
               main_load = 1'b1;
               skid_drop = 1'b1;
            end
         end
         default: ;
      endcase
   end

   mlp_stage_slot #(.W(BW)) u_main (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (main_load),
      .drop  (main_drop),
      .clear (flush),
      .data  (main_d),
      .valid (main_valid),
      .q     (main_q)
   );

   generate
      if (SKID != 0) begin : g_skid
         logic ready_q;

         mlp_stage_slot #(.W(BW)) u_skid (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (skid_load),
            .drop  (skid_drop),
            .clear (flush),
            .data  (in_bundle),
            .valid (skid_valid),
            .q     (skid_q)
         );

         // Registered copy of "skid slot will be empty"; held low through reset.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               ready_q <= 1'b0;
            end else begin
               ready_q <= flush || !(skid_load || (skid_valid && !skid_drop));
            end
         end

         assign in_ready = run && ready_q;
      end else begin : g_noskid
         assign skid_valid = 1'b0;
         assign skid_q     = '0;
         assign in_ready   = run && (!main_valid || out_ready);
      end
   endgenerate

   assign out_valid        = main_valid;
   assign out_neuron       = main_q.neuron;
   assign out_weight       = main_q.weight;
   assign out_addr         = main_q.addr;
   assign out_done         = main_q.done;
   assign out_reset_acc    = main_q.reset_acc;
   assign out_write_neuron = main_q.write_neuron;

endmodule
